// File: rtl/stn_timing_gen.sv
// STN panel timing generator: divides P_CLK into shift slots, builds line/frame
// strobes and the shift clock, and drives one of four test data patterns.
module stn_timing_gen #(
  parameter int DAT_W = 4,
  parameter int CW    = 9
) (
  input  logic             P_CLK,
  input  logic             P_RST_X,
  input  logic             P_EN,
  input  logic [1:0]       P_CNF,
  input  logic [CW-1:0]    P_HTOT,
  input  logic [CW-1:0]    P_HDP,
  input  logic [CW-1:0]    P_VTOT,
  input  logic [1:0]       P_FDLY,
  input  logic [1:0]       P_PAT,
  input  logic [CW-1:0]    P_DOTX,
  input  logic [CW-1:0]    P_DOTY,
  output logic             P_FPFRAME,
  output logic             P_FPLINE,
  output logic             P_FPSHIFT,
  output logic [DAT_W-1:0] P_FPDAT,
  output logic             P_FRM_DONE
);

  typedef enum logic [1:0] {
    PAT_ZERO = 2'b00,
    PAT_ALT  = 2'b01,
    PAT_BARS = 2'b10,
    PAT_DOT  = 2'b11
  } pat_e;

  typedef struct packed {
    logic [CW-1:0] htot;
    logic [CW-1:0] hdp;
    logic [CW-1:0] vtot;
    logic [1:0]    cnf;
    logic [1:0]    fdly;
    pat_e          pat;
  } cfg_t;

  cfg_t cfg_s;     // frame-stable shadow copy of the configuration
  cfg_t cfg_live;
  cfg_t cfg;       // configuration in force this clock
  logic first;     // first clock after reset release: shadows not yet loaded

  logic [3:0]    pcnt;
  logic [3:0]    d_m1;
  logic [3:0]    half;
  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic [CW-1:0] fon_cnt;
  logic [2:0]    fd_cnt;
  logic          alt_ph;
  logic          tick;
  logic          hwrap;
  logic          vwrap;
  logic          act;
  logic [CW:0]   thr;
  logic [DAT_W-1:0] pat_val;

  always_comb begin
    cfg_live = '{htot: P_HTOT, hdp: P_HDP, vtot: P_VTOT,
                 cnf: P_CNF, fdly: P_FDLY, pat: pat_e'(P_PAT)};
    cfg = first ? cfg_live : cfg_s;
  end

  // NOTE: every always_comb output is given a value on every path (case
  // defaults included) so no latch is inferred.
  always_comb begin
    case (cfg.cnf)
      2'b00:   d_m1 = 4'd3;
      2'b01:   d_m1 = 4'd7;
      2'b10:   d_m1 = 4'd15;
      default: d_m1 = 4'd1;
    endcase
    half  = d_m1 >> 1;
    tick  = (pcnt == d_m1);
    hwrap = tick && (hcnt == cfg.htot);
    vwrap = hwrap && (vcnt == cfg.vtot);

    thr = {1'b0, cfg.htot} + (CW+1)'(1) - {1'b0, cfg.hdp};
    act = (cfg.hdp != '0) && ((cfg.hdp > cfg.htot) || ({1'b0, hcnt} >= thr));

    case (cfg.pat)
      PAT_ZERO: pat_val = '0;
      PAT_ALT:  pat_val = {DAT_W{alt_ph}};
      PAT_BARS: pat_val = {DAT_W{hcnt[0] ^ vcnt[0]}};
      default:  pat_val = {DAT_W{(hcnt == P_DOTX) && (vcnt == P_DOTY)}};
    endcase
  end

  // NOTE: cfg_s is deliberately left out of reset; it is always reloaded in
  // the first clock after release and cfg falls back to the live inputs until then.
  always_ff @(posedge P_CLK) begin
    if (!P_RST_X || !P_EN) begin
      pcnt       <= '0;
      hcnt       <= '0;
      vcnt       <= '0;
      fd_cnt     <= '0;
      fon_cnt    <= '0;
      alt_ph     <= 1'b1;
      first      <= !P_RST_X;
      P_FPFRAME  <= 1'b0;
      P_FPLINE   <= 1'b0;
      P_FPSHIFT  <= 1'b0;
      P_FPDAT    <= '0;
      P_FRM_DONE <= 1'b0;
      if (P_RST_X) cfg_s <= cfg_live;
    end else begin
      first      <= 1'b0;
      P_FRM_DONE <= 1'b0;
      if (first || vwrap) cfg_s <= cfg_live;

      pcnt <= tick ? 4'd0 : pcnt + 4'd1;

      if (tick) begin
        hcnt      <= hwrap ? '0 : hcnt + CW'(1);
        P_FPLINE  <= hwrap;
        P_FPSHIFT <= act;
        if (hwrap) begin
          vcnt   <= vwrap ? '0 : vcnt + CW'(1);
          alt_ph <= 1'b1;
        end

        // Frame strobe: delayed start after the vertical wrap, then one line long.
        if (vwrap) begin
          fd_cnt <= {1'b0, cfg.fdly} + 3'd1;
        end else if (fd_cnt != '0) begin
          fd_cnt <= fd_cnt - 3'd1;
          if (fd_cnt == 3'd1) begin
            P_FPFRAME  <= 1'b1;
            P_FRM_DONE <= 1'b1;
            fon_cnt    <= cfg.htot;
          end
        end else if (P_FPFRAME) begin
          if (fon_cnt == '0) P_FPFRAME <= 1'b0;
          else               fon_cnt   <= fon_cnt - CW'(1);
        end
      end

      // Mid-slot: shift clock falls and data changes, half a slot before the rise.
      if (pcnt == half) begin
        P_FPSHIFT <= 1'b0;
        P_FPDAT   <= act ? pat_val : '0;
        if (act) alt_ph <= ~alt_ph;
      end
    end
  end

endmodule

// File: tb/tb_stn_timing_gen.sv
// Scoreboard bench for stn_timing_gen: stimulus pushes expected timing/data
// values, a negedge monitor pops them as the matching panel events appear.
module tb_stn_timing_gen;
  localparam int DAT_W = 8;
  localparam int CW    = 9;

  logic             clk = 1'b0;
  logic             rst_x;
  logic             en;
  logic [1:0]       cnf;
  logic [CW-1:0]    htot, hdp, vtot, dotx, doty;
  logic [1:0]       fdly, pat;
  logic             fpframe, fpline, fpshift, frm_done;
  logic [DAT_W-1:0] fpdat;

  stn_timing_gen #(.DAT_W(DAT_W), .CW(CW)) dut (
    .P_CLK(clk), .P_RST_X(rst_x), .P_EN(en), .P_CNF(cnf),
    .P_HTOT(htot), .P_HDP(hdp), .P_VTOT(vtot), .P_FDLY(fdly), .P_PAT(pat),
    .P_DOTX(dotx), .P_DOTY(doty),
    .P_FPFRAME(fpframe), .P_FPLINE(fpline), .P_FPSHIFT(fpshift),
    .P_FPDAT(fpdat), .P_FRM_DONE(frm_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int q_first[$], q_lper[$], q_lw[$], q_nsh[$], q_dat[$];
  int q_fdly[$], q_fw[$], q_fper[$], q_nz[$], q_nzv[$];

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int pending();
    return q_first.size() + q_lper.size() + q_lw.size() + q_nsh.size() +
           q_dat.size() + q_fdly.size() + q_fw.size() + q_fper.size() +
           q_nz.size() + q_nzv.size();
  endfunction

  // Monitor state
  logic run_q = 1'b0, pl = 1'b0, ps = 1'b0, pf = 1'b0;
  bit   first_pend, line_valid, fr_valid;
  int   rel_cyc, line_rise, fr_rise, nsh, nz, nzor;
  int   line_cnt = 0;

  always @(negedge clk) begin
    logic frise;
    if (!(rst_x && en)) begin
      run_q = 1'b0;
    end else begin
      if (!run_q) begin
        rel_cyc = cyc; first_pend = 1; line_valid = 0; fr_valid = 0;
        line_cnt = 0; nsh = 0; nz = 0; nzor = 0;
        pl = 1'b0; ps = 1'b0; pf = 1'b0;
      end
      run_q = 1'b1;

      if (fpshift && !ps) begin
        nsh++;
        if (first_pend) begin
          first_pend = 0;
          if (q_first.size() != 0) check("first_shift_rise", cyc - rel_cyc, q_first.pop_front());
        end
        if (q_dat.size() != 0) check("fpdat_at_shift", int'(fpdat), q_dat.pop_front());
      end
      if (fpdat != '0) begin
        nz++;
        nzor = nzor | int'(fpdat);
      end

      if (fpline && !pl) begin
        if (line_valid) begin
          if (q_lper.size() != 0) check("line_period", cyc - line_rise, q_lper.pop_front());
          if (q_nsh.size() != 0)  check("shifts_per_line", nsh, q_nsh.pop_front());
        end
        line_valid = 1; line_rise = cyc; nsh = 0; line_cnt++;
      end
      if (!fpline && pl && q_lw.size() != 0) check("line_width", cyc - line_rise, q_lw.pop_front());

      frise = fpframe && !pf;
      if (frise || frm_done) check("frm_done", int'(frm_done), int'(frise));
      if (frise) begin
        if (q_fdly.size() != 0) check("frame_delay", cyc - line_rise, q_fdly.pop_front());
        if (fr_valid && q_fper.size() != 0) check("frame_period", cyc - fr_rise, q_fper.pop_front());
        if (q_nz.size() != 0)  check("dot_cycles", nz, q_nz.pop_front());
        if (q_nzv.size() != 0) check("dot_value", nzor, q_nzv.pop_front());
        fr_valid = 1; fr_rise = cyc; nz = 0; nzor = 0;
      end
      if (!fpframe && pf && q_fw.size() != 0) check("frame_width", cyc - fr_rise, q_fw.pop_front());

      pl = fpline; ps = fpshift; pf = fpframe;
    end
  end

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (pending() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain"}, pending(), 0);
    q_first.delete(); q_lper.delete(); q_lw.delete(); q_nsh.delete(); q_dat.delete();
    q_fdly.delete(); q_fw.delete(); q_fper.delete(); q_nz.delete(); q_nzv.delete();
  endtask

  task automatic wait_lines(input int n, input int budget);
    int k = 0;
    while (line_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("wait_lines", int'(line_cnt >= n), 1);
  endtask

  task automatic set_cfg(input int c, input int ht, input int hd, input int vt,
                         input int fd, input int pt, input int dx, input int dy);
    cnf = 2'(c); htot = CW'(ht); hdp = CW'(hd); vtot = CW'(vt);
    fdly = 2'(fd); pat = 2'(pt); dotx = CW'(dx); doty = CW'(dy);
  endtask

  task automatic check_zero(input string name);
    check(name, int'({fpframe, fpline, fpshift, frm_done, fpdat}), 0);
  endtask

  initial begin
    rst_x = 1'b0;
    en    = 1'b1;
    set_cfg(0, 105, 80, 239, 2, 1, 0, 0);

    // Reset held 5 clocks with enable high
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_zero("reset_outputs");
    end

    // Line timing, alternate pattern on the first line
    q_first.push_back(108);
    for (int i = 0; i < 3; i++) begin
      q_lper.push_back(424); q_lw.push_back(4); q_nsh.push_back(80);
    end
    for (int i = 0; i < 80; i++) q_dat.push_back((i % 2 == 0) ? 255 : 0);
    @(posedge clk); #1 rst_x = 1'b1;
    drain("line_timing", 3000);

    // Enable abort at vcnt = 50, reloading a small geometry with bars
    wait_lines(50, 25000);
    repeat (100) @(posedge clk);
    #1 en = 1'b0;
    set_cfg(0, 15, 8, 9, 2, 2, 0, 0);
    q_first.push_back(36);
    for (int i = 0; i < 2; i++) begin
      q_lper.push_back(64); q_lw.push_back(4); q_nsh.push_back(8);
      q_fdly.push_back(12); q_fw.push_back(64);
    end
    q_fper.push_back(640);
    for (int i = 0; i < 16; i++) q_dat.push_back((((8 + i % 8) ^ (i / 8)) & 1) ? 255 : 0);
    @(posedge clk); #1 en = 1'b1;
    @(negedge clk);
    check_zero("en_abort_outputs");
    drain("frame_timing", 2500);

    // Shadowing: HTOT change mid-frame takes effect only after the vertical wrap
    wait_lines(23, 2000);
    #1 htot = CW'(7);
    for (int i = 0; i < 7; i++) q_lper.push_back(64);
    for (int i = 0; i < 3; i++) q_lper.push_back(32);
    for (int i = 0; i < 10; i++) q_nsh.push_back(8);
    for (int i = 0; i < 2; i++) begin
      q_fdly.push_back(12); q_fw.push_back(32);
    end
    q_fper.push_back(640);
    q_fper.push_back(320);
    drain("shadowing", 2500);

    // Dot pattern with /2 divider and zero frame delay
    @(posedge clk); #1 en = 1'b0;
    set_cfg(3, 69, 10, 119, 0, 3, 67, 118);
    q_first.push_back(122);
    for (int i = 0; i < 2; i++) begin
      q_lper.push_back(140); q_lw.push_back(2); q_nsh.push_back(10);
    end
    q_fdly.push_back(2);
    q_fw.push_back(140);
    q_nz.push_back(2);
    q_nzv.push_back(255);
    @(posedge clk); #1 en = 1'b1;
    @(negedge clk);
    check_zero("en_abort2_outputs");
    drain("dot_pattern", 17500);

    // Reset mid-line
    repeat (37) @(posedge clk);
    #1 rst_x = 1'b0;
    q_first.push_back(122);
    q_lper.push_back(140);
    @(posedge clk); #1 rst_x = 1'b1;
    @(negedge clk);
    check_zero("mid_reset_outputs");
    drain("mid_reset", 600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stn_timing_gen.md
STN_TIMING_GEN -- requirements
Module: stn_timing_gen

Interface
REQ-001 Parameter DAT_W, default 4, width of the panel data bus (legal values 4 or 8).
REQ-002 Parameter CW, default 9, width of the horizontal and vertical counters (legal values 8 to 12).
REQ-003 P_CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 P_RST_X  in  1  reset; synchronous, active-low.
REQ-005 P_EN  in  1  timing enable; high = run.
REQ-006 P_CNF  in  2  shift divider select: 00 = /4, 01 = /8, 10 = /16, 11 = /2 clocks per shift slot.
REQ-007 P_HTOT  in  CW  last horizontal slot index; a line is P_HTOT+1 slots.
REQ-008 P_HDP  in  CW  number of active (shifting) slots per line.
REQ-009 P_VTOT  in  CW  last line index; a frame is P_VTOT+1 lines.
REQ-010 P_FDLY  in  2  FPFRAME delay in slots beyond the base delay of 1.
REQ-011 P_PAT  in  2  data pattern: 00 = zero, 01 = alternate, 10 = bars, 11 = dot.
REQ-012 P_DOTX, P_DOTY  in  CW each  dot position (slot index, line index).
REQ-013 P_FPFRAME, P_FPLINE, P_FPSHIFT  out  1 each  frame strobe, line strobe and shift clock; all registered.
REQ-014 P_FPDAT  out  DAT_W  panel data; registered.
REQ-015 P_FRM_DONE  out  1  one-clock pulse at each frame wrap.

Function
REQ-016 Divider: pcnt counts 0 to D-1, where D is the selected divider value, then wraps. A slot tick occurs when pcnt = D-1.
REQ-017 hcnt increments on each slot tick and wraps from htot_s to 0. vcnt increments on each hcnt wrap and wraps from vtot_s to 0.
REQ-018 Shadow registers htot_s, hdp_s, vtot_s, cnf_s, fdly_s and pat_s load the corresponding inputs in the clock that follows reset release and at every vcnt wrap, and at no other time.
REQ-019 A slot is active when hcnt >= htot_s+1-hdp_s, computed CW+1 bits wide; if hdp_s > htot_s, every slot is active; if hdp_s = 0, no slot is active.
REQ-020 FPSHIFT in an active slot: goes low in the clock after pcnt = D/2-1 and goes high in the clock after pcnt = D-1.
REQ-021 FPSHIFT in an inactive slot: goes low in the clock after either of those pcnt points and stays low.
REQ-022 FPLINE is high for exactly one slot: the slot after hcnt wraps, aligned to slot ticks.
REQ-023 FPFRAME is high for exactly one line period. It rises 1+fdly_s slot ticks after the slot tick on which vcnt wraps.
REQ-024 P_FPDAT updates only in the clock after pcnt = D/2-1 of an active slot, so it is stable at each FPSHIFT rising edge. In inactive slots P_FPDAT is 0.
REQ-025 Pattern 00: all zeros.
REQ-026 Pattern 01: all-ones and all-zeros alternate on successive active slots, starting with ones at the first active slot of each line.
REQ-027 Pattern 10: every bit = hcnt[0] XOR vcnt[0].
REQ-028 Pattern 11: all-ones only when hcnt = P_DOTX and vcnt = P_DOTY (both sampled live); zero otherwise.
REQ-029 P_FRM_DONE pulses in the same clock as FPFRAME's first high clock.
REQ-030 When P_EN is low at a clock edge: all counters are cleared, all outputs go to 0, and the shadow registers reload.
REQ-031 When P_EN returns high, timing restarts from pcnt = hcnt = vcnt = 0.
REQ-032 Width handling: all counter compares are exact at CW bits; counter increments never carry beyond CW bits.

Reset
REQ-033 While P_RST_X is low at a clock edge: pcnt, hcnt, vcnt = 0 and every output = 0. Assertion mid-frame takes effect at the next edge, with no partial pulse.
REQ-034 The first slot tick after reset release occurs D clocks after release.

Verification
REQ-035 Reset: hold P_RST_X low for 5 clocks with P_EN = 1 -> every output is 0. After release, the first FPSHIFT rise occurs only inside an active slot.
REQ-036 Line timing: HTOT = 105, HDP = 80, CNF = 00 -> FPLINE period = 424 clocks and FPLINE width = 4 clocks; exactly 80 FPSHIFT rising edges between consecutive FPLINE pulses.
REQ-037 Frame timing: VTOT = 239, FDLY = 2 -> FPFRAME period = 240 lines and FPFRAME width = 424 clocks; FPFRAME rises 12 clocks after the slot tick on which vcnt wraps; P_FRM_DONE coincides with that rise.
REQ-038 Shadowing: change HTOT from 105 to 63 while vcnt = 100 -> line period stays 424 clocks until the next vcnt wrap, then becomes 256 clocks.
REQ-039 Dot pattern: PAT = 11, DOTX = 67, DOTY = 118, DAT_W = 8 -> P_FPDAT = 8'hFF during exactly one slot per frame; zero everywhere else.
REQ-040 Abort: drop P_EN for 1 clock at vcnt = 50, or assert reset mid-line -> all outputs are 0 the next clock; timing restarts at count 0 with no FPSHIFT glitch.
